// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake and FIFO write-port signals shared through the round-robin arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;
  logic                          busy;
  logic [ID_W-1:0]               grant_id;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, busy, grant_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter locking the transmit FIFO write port to one requester for a bounded burst.
//   state  | meaning
//   IDLE   | no owner; pick next requester after last_owner
//   LOCKED | owner streams bytes until last, burst limit or idle timeout
module fifo_wr_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             reset,
  fifo_wr_arbiter_if.slave bus
);
  localparam int         ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] BURST_LIM = 5'(MAX_BURST);
  localparam logic [7:0] IDLE_LIM  = 8'(IDLE_TIMEOUT);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       owner, owner_nxt;
  logic [ID_W-1:0]       last_owner, last_owner_nxt;
  logic [4:0]            beat_cnt, beat_cnt_nxt;
  logic [7:0]            idle_cnt, idle_cnt_nxt;
  logic                  found;
  logic [ID_W-1:0]       pick;
  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  accept;

  // Search above last_owner first, then wrap to the low indices.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (ID_W'(i) > last_owner)) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && bus.req_valid[i] && (ID_W'(i) <= last_owner)) begin
        found = 1'b1;
        pick  = ID_W'(i);
      end
    end
  end

  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == owner) begin
        own_valid = bus.req_valid[i];
        own_last  = bus.req_last[i];
        own_data  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    owner_nxt        = owner;
    last_owner_nxt   = last_owner;
    beat_cnt_nxt     = beat_cnt;
    idle_cnt_nxt     = idle_cnt;
    accept           = 1'b0;
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt    = LOCKED;
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
          idle_cnt_nxt = '0;
        end
      end
      LOCKED: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          bus.req_ready[i] = (ID_W'(i) == owner) && !bus.fifo_full;
        end
        accept           = own_valid && !bus.fifo_full;
        bus.fifo_wr_en   = accept;
        bus.fifo_wr_data = own_data;
        if (accept) begin
          beat_cnt_nxt = beat_cnt + 5'd1;
          idle_cnt_nxt = '0;
          if (own_last || (beat_cnt + 5'd1 == BURST_LIM)) begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
          end
        end else if (!own_valid && !bus.fifo_full) begin
          // A full FIFO is a stall, not owner inactivity, so it never advances the timeout.
          idle_cnt_nxt = idle_cnt + 8'd1;
          if (idle_cnt + 8'd1 == IDLE_LIM) begin
            state_nxt      = IDLE;
            last_owner_nxt = owner;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= ID_W'(NUM_REQ - 1);
      beat_cnt   <= '0;
      idle_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      idle_cnt   <= idle_cnt_nxt;
    end
  end

  assign bus.busy     = (state == LOCKED);
  assign bus.grant_id = owner;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: packet queues per requester, a transaction-level reference model,
// directed scenarios with literal expectations, then a randomized soak.
module tb_fifo_wr_arbiter;
  localparam int N  = 3;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int IT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [N-1:0]    valid_v, last_v;
  logic [N*DW-1:0] data_v;
  logic            full_v;
  logic [8:0]      pq [N][$];
  int              pause [N];
  logic [N-1:0]    acc_mask;

  bit m_locked;
  int m_owner, m_last, m_beats, m_idles;

  bit         mon_busy;
  int         mon_beats;
  int         dut_grants[$];
  int         dut_bursts[$];
  logic [7:0] dut_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bus();
    bus.req_valid = valid_v;
    bus.req_data  = data_v;
    bus.req_last  = last_v;
    bus.fifo_full = full_v;
  endtask

  task automatic add_packet(input int r, input int len, input logic [7:0] base);
    for (int b = 0; b < len; b++) pq[r].push_back({(b == len - 1), 8'(base + b)});
  endtask

  // Reference: arbitration picks the first valid index after the previous owner, with wrap.
  task automatic model_advance();
    int c;
    if (!m_locked) begin
      if (valid_v != '0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (valid_v[c]) begin
            m_owner = c;
            break;
          end
        end
        m_locked = 1'b1;
        m_beats  = 0;
        m_idles  = 0;
      end
    end else if (!full_v) begin
      if (valid_v[m_owner]) begin
        m_beats++;
        m_idles = 0;
        if (last_v[m_owner] || m_beats == MB) begin
          m_locked = 1'b0;
          m_last   = m_owner;
        end
      end else begin
        m_idles++;
        if (m_idles == IT) begin
          m_locked = 1'b0;
          m_last   = m_owner;
        end
      end
    end
  endtask

  // One clock cycle: entered and left at a falling edge.
  task automatic step();
    logic [N-1:0]  e_ready;
    logic          e_wr;
    logic [DW-1:0] e_data;
    drive_bus();
    #1;
    e_ready = '0;
    if (m_locked && !full_v) e_ready[m_owner] = 1'b1;
    e_wr   = m_locked && valid_v[m_owner] && !full_v;
    e_data = data_v[m_owner*DW +: DW];
    check("req_ready", bus.req_ready, e_ready);
    check("fifo_wr_en", bus.fifo_wr_en, e_wr);
    check("busy", bus.busy, m_locked);
    check("grant_id", bus.grant_id, m_owner);
    if (m_locked) check("fifo_wr_data", bus.fifo_wr_data, e_data);
    if (bus.busy && !mon_busy) begin
      dut_grants.push_back(int'(bus.grant_id));
      mon_beats = 0;
    end
    if (bus.busy && bus.fifo_wr_en) begin
      mon_beats++;
      dut_bytes.push_back(bus.fifo_wr_data);
    end
    if (!bus.busy && mon_busy) dut_bursts.push_back(mon_beats);
    mon_busy = bus.busy;
    acc_mask = valid_v & e_ready;
    model_advance();
    @(negedge clk);
  endtask

  task automatic run_queues(input int ncyc, input bit rnd, input bit full_hold);
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (rnd) begin
          if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
            add_packet(i, $urandom_range(1, 7), 8'($urandom));
          if (pause[i] == 0 && $urandom_range(0, 40) == 0) pause[i] = $urandom_range(3, 12);
        end
        if (pause[i] > 0) pause[i]--;
        valid_v[i] = (pq[i].size() > 0) && (pause[i] == 0) && (!rnd || $urandom_range(0, 9) != 0);
        if (pq[i].size() > 0) begin
          data_v[i*DW +: DW] = pq[i][0][7:0];
          last_v[i]          = pq[i][0][8];
        end else begin
          data_v[i*DW +: DW] = 8'($urandom);
          last_v[i]          = 1'($urandom);
        end
      end
      full_v = full_hold ? 1'b1 : (rnd && $urandom_range(0, 4) == 0);
      step();
      for (int i = 0; i < N; i++) if (acc_mask[i]) void'(pq[i].pop_front());
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    m_locked = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
    m_beats  = 0;
    m_idles  = 0;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      pause[i] = 0;
    end
    valid_v = '0;
    last_v  = '0;
    data_v  = '0;
    full_v  = 1'b0;
    drive_bus();
    dut_grants.delete();
    dut_bursts.delete();
    dut_bytes.delete();
    mon_busy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_ints(input string name, input int got[$], input int exp[$]);
    check({name, "_count"}, got.size(), exp.size());
    for (int k = 0; k < exp.size() && k < got.size(); k++) check(name, got[k], exp[k]);
  endtask

  initial begin
    int n;
    logic [7:0] eb;
    int exp_g[$];
    int exp_b[$];

    // Reset values while requesters are all active
    reset   = 1'b1;
    valid_v = '1;
    last_v  = '0;
    data_v  = 24'h5A_C3_7E;
    full_v  = 1'b0;
    drive_bus();
    #3;
    check("rst_ready", bus.req_ready, 0);
    check("rst_wr_en", bus.fifo_wr_en, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_wr_data", bus.fifo_wr_data, 0);
    @(negedge clk);

    // Single requester, short packet
    do_reset();
    add_packet(1, 3, 8'hA1);
    run_queues(1, 1'b0, 1'b0);
    check("t1_busy", bus.busy, 1);
    check("t1_grant_id", bus.grant_id, 1);
    check("t1_ready", bus.req_ready, 3'b010);
    check("t1_wr_en", bus.fifo_wr_en, 1);
    check("t1_wr_data", bus.fifo_wr_data, 8'hA1);
    run_queues(3, 1'b0, 1'b0);
    check("t1_busy_after", bus.busy, 0);
    check("t1_grant_id_after", bus.grant_id, 1);
    check("t1_bytes_count", dut_bytes.size(), 3);
    for (int k = 0; k < 3 && k < dut_bytes.size(); k++) begin
      eb = 8'hA1 + 8'(k);
      check("t1_byte", dut_bytes[k], eb);
    end

    // Three continuous requesters with 6-byte packets
    do_reset();
    for (int i = 0; i < N; i++) add_packet(i, 6, 8'(8'h10 * (i + 1)));
    run_queues(30, 1'b0, 1'b0);
    exp_g = '{0, 1, 2, 0, 1, 2};
    exp_b = '{4, 4, 4, 2, 2, 2};
    check_ints("t2_grant", dut_grants, exp_g);
    check_ints("t2_burst", dut_bursts, exp_b);

    // FIFO full for 5 cycles mid-burst of req2
    do_reset();
    add_packet(2, 4, 8'hC1);
    run_queues(3, 1'b0, 1'b0);
    run_queues(5, 1'b0, 1'b1);
    check("t3_busy", bus.busy, 1);
    check("t3_grant_id", bus.grant_id, 2);
    check("t3_wr_en", bus.fifo_wr_en, 0);
    check("t3_ready", bus.req_ready, 0);
    run_queues(8, 1'b0, 1'b0);
    exp_g = '{2};
    exp_b = '{4};
    check_ints("t3_grant", dut_grants, exp_g);
    check_ints("t3_burst", dut_bursts, exp_b);
    check("t3_bytes_count", dut_bytes.size(), 4);
    for (int k = 0; k < 4 && k < dut_bytes.size(); k++) begin
      eb = 8'hC1 + 8'(k);
      check("t3_byte", dut_bytes[k], eb);
    end

    // Owner goes quiet after two bytes while req1 waits
    do_reset();
    add_packet(0, 5, 8'h40);
    add_packet(1, 2, 8'h50);
    run_queues(3, 1'b0, 1'b0);
    pause[0] = 100;
    n = 0;
    while (bus.busy && n < 20) begin
      run_queues(1, 1'b0, 1'b0);
      n++;
    end
    check("t4_idle_cycles", n, IT);
    run_queues(1, 1'b0, 1'b0);
    check("t4_next_busy", bus.busy, 1);
    check("t4_next_grant_id", bus.grant_id, 1);

    // Last flag coinciding with the burst limit releases once
    do_reset();
    add_packet(0, 4, 8'h60);
    add_packet(2, 2, 8'h70);
    run_queues(15, 1'b0, 1'b0);
    exp_g = '{0, 2};
    exp_b = '{4, 2};
    check_ints("t5_grant", dut_grants, exp_g);
    check_ints("t5_burst", dut_bursts, exp_b);

    // Asynchronous reset in the middle of a burst
    do_reset();
    add_packet(1, 4, 8'hB0);
    run_queues(2, 1'b0, 1'b0);
    check("t6_wr_en_pre", bus.fifo_wr_en, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_wr_en", bus.fifo_wr_en, 0);
    check("t6_rst_ready", bus.req_ready, 0);
    check("t6_rst_grant_id", bus.grant_id, 0);
    check("t6_rst_wr_data", bus.fifo_wr_data, 0);
    @(negedge clk);
    do_reset();
    add_packet(0, 2, 8'h10);
    add_packet(1, 2, 8'h20);
    run_queues(1, 1'b0, 1'b0);
    check("t6_first_busy", bus.busy, 1);
    check("t6_first_grant_id", bus.grant_id, 0);
    run_queues(8, 1'b0, 1'b0);

    // Randomized soak against the reference model
    do_reset();
    run_queues(2500, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
